// File: rtl/systolic_feeder.sv
// Skews row vectors onto a systolic array: lane i is delayed i+1 cycles, then the
// FSM flushes for 2*array_size-1 cycles. Define SYSTOLIC_FEEDER_STATS_EN for vec_count.

module systolic_feeder_lane #(
  parameter int DEPTH = 1,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_vld,
  input  logic [W-1:0] in_elem,
  output logic [W-1:0] out_elem,
  output logic         out_vld
);
  logic [DEPTH-1:0][W-1:0] elem_q, elem_d;
  logic [DEPTH-1:0]        vld_pipe_q, vld_pipe_d;

  // Stage 0 takes the new element or a zero bubble; the line never stalls.
  always_comb begin
    elem_d        = '0;
    vld_pipe_d    = '0;
    elem_d[0]     = in_vld ? in_elem : '0;
    vld_pipe_d[0] = in_vld;
    for (int k = 1; k < DEPTH; k++) begin
      elem_d[k]     = elem_q[k-1];
      vld_pipe_d[k] = vld_pipe_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      elem_q     <= '0;
      vld_pipe_q <= '0;
    end else begin
      elem_q     <= elem_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  assign out_elem = elem_q[DEPTH-1];
  assign out_vld  = vld_pipe_q[DEPTH-1];
endmodule

module systolic_feeder #(
  parameter int array_size = 2,
  parameter int data_size  = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [data_size*array_size-1:0] in_data,
  input  logic                            in_last,
  output logic [data_size*array_size-1:0] datain,
  output logic [array_size-1:0]           lane_valid,
  output logic                            busy,
  output logic                            done
`ifdef SYSTOLIC_FEEDER_STATS_EN
  ,
  output logic [15:0]                     vec_count
`endif
);
  localparam int CW = $clog2(2*array_size);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(2*array_size-2);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            accept;
  logic [array_size-1:0][data_size-1:0] lane_data;

  assign in_ready = (state_q != FLUSH);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

  for (genvar i = 0; i < array_size; i++) begin : g_lane
    systolic_feeder_lane #(.DEPTH(i+1), .W(data_size)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .in_vld   (accept),
      .in_elem  (in_data[i*data_size +: data_size]),
      .out_elem (lane_data[i]),
      .out_vld  (lane_valid[i])
    );
  end

  assign datain = lane_data;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        state_d = in_last ? FLUSH : STREAM;
        cnt_d   = '0;
      end
      STREAM: if (accept && in_last) begin
        state_d = FLUSH;
        cnt_d   = '0;
      end
      FLUSH: if (cnt_q == FLUSH_LAST) begin
        // done is registered so it lands on the first IDLE cycle
        state_d = IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

`ifdef SYSTOLIC_FEEDER_STATS_EN
  logic [15:0] vec_count_q, vec_count_d;

  always_comb begin
    vec_count_d = vec_count_q;
    if (accept && (vec_count_q != 16'hFFFF)) vec_count_d = vec_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vec_count_q <= '0;
    else        vec_count_q <= vec_count_d;
  end

  assign vec_count = vec_count_q;
`endif
endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder (array_size=2, data_size=8): the driver queues
// hand-computed per-cycle expectations, a negedge monitor pops and compares them.

module tb_systolic_feeder;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic [15:0] datain;
  logic [1:0]  lane_valid;
  logic        busy;
  logic        done;
`ifdef SYSTOLIC_FEEDER_STATS_EN
  logic [15:0] vec_count;
`endif

  systolic_feeder #(.array_size(2), .data_size(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .datain     (datain),
    .lane_valid (lane_valid),
    .busy       (busy),
    .done       (done)
`ifdef SYSTOLIC_FEEDER_STATS_EN
    ,
    .vec_count  (vec_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] d;
    logic [1:0]  lv;
    logic        rdy;
    logic        bsy;
    logic        dn;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  // Monitor: compare every expectation whose target cycle has arrived.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL stale_expectation: got cyc %0d, expected cyc %0d", cyc, e.cyc);
      end else begin
        chk("datain",     datain,            e.d);
        chk("lane_valid", {14'd0, lane_valid}, {14'd0, e.lv});
        chk("in_ready",   {15'd0, in_ready},   {15'd0, e.rdy});
        chk("busy",       {15'd0, busy},       {15'd0, e.bsy});
        chk("done",       {15'd0, done},       {15'd0, e.dn});
      end
    end
  end

  // Drive one edge's inputs and queue what the outputs must be after that edge.
  task automatic step(input logic v, input logic [15:0] d, input logic l,
                      input logic [15:0] ed, input logic [1:0] elv,
                      input logic erdy, input logic ebsy, input logic edn);
    exp_t e;
    in_valid = v;
    in_data  = d;
    in_last  = l;
    e.cyc = cyc + 1; e.d = ed; e.lv = elv; e.rdy = erdy; e.bsy = ebsy; e.dn = edn;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_datain"},     datain,              16'h0000);
    chk({tag, "_lane_valid"}, {14'd0, lane_valid}, 16'h0000);
    chk({tag, "_busy"},       {15'd0, busy},       16'h0000);
    chk({tag, "_done"},       {15'd0, done},       16'h0000);
  endtask

  initial begin
    int budget;
    reset = 1'b0; in_valid = 1'b0; in_data = 16'h0; in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk_idle("rst");
    chk("rst_in_ready", {15'd0, in_ready}, 16'h0001);

    // Skew + flush/done: 2211 then 4433(last).
    step(1, 16'h2211, 0, 16'h0011, 2'b01, 1, 1, 0);
    step(1, 16'h4433, 1, 16'h2233, 2'b11, 0, 1, 0);
    step(0, 16'hFFFF, 1, 16'h4400, 2'b10, 0, 1, 0);
    step(0, 16'hFFFF, 1, 16'h0000, 2'b00, 0, 1, 0);
    step(0, 16'hFFFF, 1, 16'h0000, 2'b00, 1, 0, 1);
    step(0, 16'hFFFF, 1, 16'h0000, 2'b00, 1, 0, 0);

    // Bubble between two vectors, garbage on in_data/in_last while idle.
    step(1, 16'hBBAA, 0, 16'h00AA, 2'b01, 1, 1, 0);
    step(0, 16'hFFFF, 1, 16'hBB00, 2'b10, 1, 1, 0);
    step(1, 16'hDDCC, 1, 16'h00CC, 2'b01, 0, 1, 0);
    step(0, 16'hFFFF, 0, 16'hDD00, 2'b10, 0, 1, 0);
    step(0, 16'hFFFF, 0, 16'h0000, 2'b00, 0, 1, 0);
    step(0, 16'hFFFF, 0, 16'h0000, 2'b00, 1, 0, 1);
    // Accept in the done cycle.
    step(1, 16'h6655, 0, 16'h0055, 2'b01, 1, 1, 0);
    step(1, 16'h8877, 1, 16'h6677, 2'b11, 0, 1, 0);
    step(0, 16'hFFFF, 0, 16'h8800, 2'b10, 0, 1, 0);
`ifdef SYSTOLIC_FEEDER_STATS_EN
    chk("vec_count_pre", vec_count, 16'd6);
`endif

    // Mid-FLUSH reset.
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk_idle("midrst");
`ifdef SYSTOLIC_FEEDER_STATS_EN
    chk("vec_count_rst", vec_count, 16'd0);
`endif
    @(posedge clk);
    #1 reset = 1'b1;
    step(0, 16'hFFFF, 0, 16'h0000, 2'b00, 1, 0, 0);
    step(0, 16'hFFFF, 0, 16'h0000, 2'b00, 1, 0, 0);
    step(1, 16'h1234, 1, 16'h0034, 2'b01, 0, 1, 0);

    budget = 0;
    while (sb.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
